// File: rtl/fifo_uart_tx.sv
// UART transmitter: one FIFO read per frame, then start / data LSB-first / optional even parity / stop bits.
// First start bit 3 cycles after IDLE sees data; no drain while busy or i_en=0; a read left unanswered for 2 cycles is abandoned.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_fifo_empty,
   input  logic [WIDTH-1:0] i_fifo_rd_data,
   input  logic             i_fifo_ready_pulse,
   output logic             o_fifo_rd_en,
   output logic             o_tx,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_underrun
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_INC  = BW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
   localparam logic [IW-1:0] IDX_INC   = IW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    baud_q, baud_d;
   logic [IW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             par_q, par_d;
   logic [1:0]       wait_q, wait_d;
   logic             tx_q, tx_d;
   logic             rd_en_q, rd_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             und_q, und_d;
   logic             baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      wait_d  = wait_q;
      und_d   = 1'b0;
      case (state_q)
         S_IDLE: if (i_en && !i_fifo_empty) state_d = S_REQ;
         S_REQ: begin
            wait_d  = 2'd0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Third WAIT cycle only retires the underrun; a late pulse is not accepted.
            if (wait_q == 2'd2) begin
               state_d = S_IDLE;
            end else if (i_fifo_ready_pulse) begin
               shift_d = i_fifo_rd_data;
               par_d   = ^i_fifo_rd_data;
               baud_d  = '0;
               state_d = S_START;
            end else begin
               wait_d = wait_q + 2'd1;
               und_d  = (wait_q == 2'd1);
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_INC;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == IDX_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + IDX_INC;
               end
            end else begin
               baud_d = baud_q + BAUD_INC;
            end
         end
         S_PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_STOP;
            end else begin
               baud_d = baud_q + BAUD_INC;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + IDX_INC;
               end
            end else begin
               baud_d = baud_q + BAUD_INC;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so the registered pins line up with state_q.
      rd_en_d = (state_d == S_REQ);
      busy_d  = (state_d != S_IDLE) && !und_d;
      done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         wait_q  <= 2'd0;
         tx_q    <= 1'b1;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         wait_q  <= wait_d;
         tx_q    <= tx_d;
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         und_q   <= und_d;
      end
   end

   assign o_tx         = tx_q;
   assign o_fifo_rd_en = rd_en_q;
   assign o_busy       = busy_q;
   assign o_frame_done = done_q;
   assign o_underrun   = und_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2) fed by a lagging-empty FIFO model, line decoded by a scoreboard.
module tb_fifo_uart_tx;
   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
   endtask

   // Expected line bits of one frame, index 0 = start bit; unused upper positions read as idle high.
   function automatic logic [11:0] frame_bits(input logic [7:0] b, input int pe);
      logic [11:0] v;
      v    = '1;
      v[0] = 1'b0;
      for (int i = 0; i < 8; i++) v[i + 1] = b[i];
      if (pe != 0) v[9] = (($countones(b) % 2) != 0);
      return v;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : ch
      localparam int PE = g;
      localparam int SB = g + 1;
      localparam int NB = 1 + 8 + PE + SB;

      logic       rst, en, empty, ready, rd_en, tx, busy, done, und, stall, fin;
      logic [7:0] rd_data;
      logic [7:0] fifo_q[$];
      logic [7:0] exp_q[$];
      int         gaps[$];
      int         cyc = 0;
      int         rd_cnt, done_cnt, und_cnt, last_rd;

      fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .STOP_BITS(SB)) dut (
         .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(empty),
         .i_fifo_rd_data(rd_data), .i_fifo_ready_pulse(ready),
         .o_fifo_rd_en(rd_en), .o_tx(tx), .o_busy(busy),
         .o_frame_done(done), .o_underrun(und)
      );

      always @(posedge clk) cyc++;

      // FIFO model: ready/data the cycle after a read request, empty flag one cycle stale.
      initial begin
         logic r;
         logic e;
         ready = 1'b0; rd_data = '0; empty = 1'b1;
         forever begin
            @(negedge clk);
            r = rd_en;
            e = (fifo_q.size() == 0);
            @(posedge clk); #1;
            if (r && !stall && fifo_q.size() > 0) begin
               rd_data = fifo_q.pop_front();
               ready   = 1'b1;
            end else begin
               ready = 1'b0;
            end
            empty = stall ? 1'b0 : e;
         end
      end

      initial begin
         rd_cnt = 0; done_cnt = 0; und_cnt = 0; last_rd = -100;
         forever begin
            @(negedge clk);
            if (rd_en) begin rd_cnt++; last_rd = cyc; end
            if (done) done_cnt++;
            if (und) begin
               und_cnt++;
               chk($sformatf("ch%0d underrun_latency", g), cyc - last_rd, 3);
               chk($sformatf("ch%0d underrun_tx_high", g), int'(tx), 1);
            end
         end
      end

      // Line scoreboard: every cycle of a frame compared with the expected bit pattern.
      initial begin
         logic [7:0]  b;
         logic [11:0] want, got;
         int start_cyc, last_done, mism, done_at, done_n, busy_low;
         bit abort;
         last_done = -100;
         forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) continue;
            start_cyc = cyc;
            chk($sformatf("ch%0d start_latency", g), start_cyc - last_rd, 2);
            gaps.push_back(start_cyc - last_done - 1);
            chk($sformatf("ch%0d frame_expected", g), int'(exp_q.size() > 0), 1);
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            want = frame_bits(b, PE);
            got = '1; mism = 0; done_at = -1; done_n = 0; busy_low = 0; abort = 0;
            for (int k = 0; k < NB * CPB; k++) begin
               if (k > 0) @(negedge clk);
               if (rst) begin abort = 1; break; end
               if (k % CPB == CPB / 2) got[k / CPB] = tx;
               if (tx !== want[k / CPB]) mism++;
               if (done === 1'b1) begin done_n++; if (done_at < 0) done_at = k; end
               if (busy !== 1'b1) busy_low++;
            end
            if (!abort) begin
               chk($sformatf("ch%0d frame_bits", g), int'(got), int'(want));
               chk($sformatf("ch%0d bit_cycle_mismatches", g), mism, 0);
               chk($sformatf("ch%0d frame_done_cycle", g), done_at, NB * CPB - 1);
               chk($sformatf("ch%0d frame_done_count", g), done_n, 1);
               chk($sformatf("ch%0d busy_low_in_frame", g), busy_low, 0);
               last_done = cyc;
               @(negedge clk);
               chk($sformatf("ch%0d busy_after_done", g), int'(busy), 0);
            end
         end
      end

      task automatic step(input int n);
         repeat (n) begin @(posedge clk); #2; end
      endtask

      task automatic push(input logic [7:0] b);
         fifo_q.push_back(b);
         exp_q.push_back(b);
      endtask

      task automatic drain(input int max);
         int t;
         t = 0;
         while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && t < max) begin
            step(1); t++;
         end
         if (t >= max) chk($sformatf("ch%0d drain_timeout", g), exp_q.size() + fifo_q.size(), 0);
         step(5);
      endtask

      task automatic wait_start(input int max);
         int t;
         t = 0;
         while (tx !== 1'b0 && t < max) begin step(1); t++; end
         if (t >= max) chk($sformatf("ch%0d start_timeout", g), int'(tx), 0);
      endtask

      initial begin
         int r0, d0, u0, t;
         rst = 1'b1; en = 1'b0; stall = 1'b0; fin = 1'b0;
         step(3);
         chk($sformatf("ch%0d reset_outputs", g), int'({tx, rd_en, busy, done, und}), 5'b10000);
         rst = 1'b0;
         step(2);

         // Directed single frames.
         en = 1'b1;
         r0 = rd_cnt;
         if (g == 0) begin
            push(8'hA5); drain(300);
            chk($sformatf("ch%0d single_read_pulses", g), rd_cnt - r0, 1);
         end else begin
            push(8'h07); drain(300);
            push(8'h03); drain(300);
            chk($sformatf("ch%0d parity_read_pulses", g), rd_cnt - r0, 2);
         end

         // Back-to-back.
         r0 = rd_cnt; d0 = done_cnt;
         gaps.delete();
         push(8'h00); push(8'hFF); push(8'h55);
         drain(600);
         step(50);
         chk($sformatf("ch%0d b2b_read_pulses", g), rd_cnt - r0, 3);
         chk($sformatf("ch%0d b2b_done_pulses", g), done_cnt - d0, 3);
         chk($sformatf("ch%0d b2b_gap_count", g), gaps.size(), 3);
         if (gaps.size() >= 3) begin
            chk($sformatf("ch%0d b2b_gap1", g), gaps[1], 3);
            chk($sformatf("ch%0d b2b_gap2", g), gaps[2], 3);
         end

         // Random bytes with random spacing.
         for (int i = 0; i < 8; i++) begin
            push(8'($urandom));
            step($urandom_range(0, 60));
         end
         drain(1500);

         // Underrun: empty held low with nothing to return.
         u0 = und_cnt; d0 = done_cnt;
         stall = 1'b1;
         step(30);
         stall = 1'b0;
         chk($sformatf("ch%0d underrun_retries", g), int'(und_cnt - u0 >= 2), 1);
         chk($sformatf("ch%0d underrun_no_frame", g), done_cnt - d0, 0);
         step(15);
         drain(100);

         // Enable gating.
         en = 1'b0;
         r0 = rd_cnt; d0 = done_cnt;
         push(8'h3C); push(8'hC3);
         step(100);
         chk($sformatf("ch%0d gated_no_read", g), rd_cnt - r0, 0);
         en = 1'b1;
         wait_start(20);
         step(5);
         en = 1'b0;
         step(NB * CPB + 60);
         chk($sformatf("ch%0d gated_one_read", g), rd_cnt - r0, 1);
         chk($sformatf("ch%0d gated_one_frame", g), done_cnt - d0, 1);

         // Reset during data bit 3 of the frame carrying the left-over byte.
         push(8'h96);
         en = 1'b1;
         wait_start(40);
         step(4 * CPB + 1);
         rst = 1'b1;
         #1;
         chk($sformatf("ch%0d reset_tx_high", g), int'(tx), 1);
         chk($sformatf("ch%0d reset_busy_low", g), int'(busy), 0);
         step(3);
         rst = 1'b0;
         t = 0;
         drain(400);
         chk($sformatf("ch%0d all_bytes_sent", g), exp_q.size(), 0);
         fin = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(ch[0].fin && ch[1].fin) && t < 50000) begin
         @(posedge clk); t++;
      end
      if (t >= 50000) chk("global_timeout", int'({ch[0].fin, ch[1].fin}), 3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains bytes from the upstream `fifo` read port and serializes them onto a single TX line. It sits directly downstream of the FIFO. It issues one read per frame, captures the word returned with the FIFO's ready pulse, and shifts it out as start, data (LSB first), optional even-parity and stop bits. Drain is gated by an enable so software can hold the queue.

## Interface
- `WIDTH`, default 8: data bits per frame; must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, default 868: clock cycles per bit. Must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after the data bits.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_en` in 1: drain enable, level-sensitive.
- `i_fifo_empty` in 1: FIFO empty flag. It is registered upstream and lags the FIFO count by one cycle.
- `i_fifo_rd_data` in `WIDTH`: FIFO read data; valid when `i_fifo_ready_pulse`=1.
- `i_fifo_ready_pulse` in 1: one-cycle strobe from the FIFO when read data is valid.
- `o_fifo_rd_en` out 1: one-cycle read request to the FIFO.
- `o_tx` out 1: serial line; idles high.
- `o_busy` out 1: high from the read request until the end of the last stop bit.
- `o_frame_done` out 1: one-cycle pulse in the last cycle of the final stop bit.
- `o_underrun` out 1: one-cycle pulse when a read request gets no ready pulse.

## Operation
- All outputs are registered. Reset values:
  - `o_tx`=1
  - `o_fifo_rd_en`=0, `o_busy`=0, `o_frame_done`=0, `o_underrun`=0
  - state IDLE; baud counter, bit index and shift register all 0.
- State machine: IDLE → REQ → WAIT → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE**: if `i_en`=1 and `i_fifo_empty`=0, go to REQ. Otherwise stay, with `o_tx`=1.
- **REQ**: `o_fifo_rd_en`=1 for exactly this one cycle; `o_busy`=1. Then go to WAIT.
- **WAIT**: on `i_fifo_ready_pulse`=1, latch `i_fifo_rd_data` into the shift register and go to START.
  - If no pulse arrives within 2 cycles of entering WAIT, pulse `o_underrun`, drop `o_busy` and return to IDLE.
  - `o_tx` stays 1 throughout WAIT.
- **START**: `o_tx`=0 for `CLKS_PER_BIT` cycles.
- **DATA**: `WIDTH` bits, LSB first, each held `CLKS_PER_BIT` cycles. The bit index runs 0..`WIDTH`-1.
- **PARITY** (only if `PARITY_EN`=1): `o_tx` = XOR of all latched data bits, giving even parity over data plus parity bit.
- **STOP**: `o_tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. `o_frame_done`=1 in the final cycle; the next state is IDLE.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - It is cleared on entry to START.
- `i_en` is only sampled in IDLE. Deasserting it mid-frame lets the frame complete and blocks the next request.
- Exactly one read request per frame; a second request is never issued before the current frame ends. The lagging empty flag therefore cannot cause a read of an empty FIFO.
- `i_fifo_ready_pulse` is ignored outside WAIT.
- Reset mid-frame:
  - `o_tx` goes to 1 and `o_busy` to 0 immediately (asynchronous).
  - The partial frame is abandoned and the latched data is discarded.

## Timing
- Cycle N: IDLE sees `i_en`=1 and `i_fifo_empty`=0.
- N+1: `o_fifo_rd_en`=1.
- N+2: FIFO returns `i_fifo_ready_pulse` with data.
- N+3: `o_tx`=0, first start-bit cycle.
- Frame length from the first start cycle to `o_frame_done` inclusive: `CLKS_PER_BIT`×(1+`WIDTH`+`PARITY_EN`+`STOP_BITS`) cycles.
- Back-to-back frames: IDLE is re-entered the cycle after `o_frame_done`. With data available, the line stays high for exactly 3 extra cycles (IDLE, REQ, WAIT) between the last stop cycle and the next start bit.
- Underrun timing: with `o_fifo_rd_en` at N+1 and no ready pulse at N+2 or N+3, `o_underrun`=1 at N+4 and the state is IDLE at N+5.
- `o_busy` rises at N+1 and falls the cycle after `o_frame_done`.

## Test plan
- **Single frame**: `CLKS_PER_BIT`=4, `WIDTH`=8, `PARITY_EN`=0, `STOP_BITS`=1; push 0xA5 into the FIFO.
  - Expect one `o_fifo_rd_en` pulse.
  - `o_tx` shows 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
  - `o_frame_done` fires on cycle 40 after the start bit begins.
- **Parity**: `PARITY_EN`=1, `STOP_BITS`=2; send 0x07.
  - Parity bit = 1, followed by 8 high stop cycles.
  - 0x03 gives parity bit = 0.
- **Back-to-back**: push 0x00, 0xFF, 0x55.
  - Exactly 3 read pulses and 3 `o_frame_done` pulses.
  - 3-cycle high gap between frames.
  - Bytes received in order.
  - No read after the FIFO empties.
- **Underrun**: hold `i_fifo_empty`=0 with no ready pulse.
  - `o_underrun` fires one cycle, 3 cycles after `o_fifo_rd_en`.
  - `o_tx` stays 1; a retry follows from IDLE.
- **Enable gating**: load 2 bytes with `i_en`=0 → no read for 100 cycles. Set `i_en`=1, then clear it during frame 1 → frame 1 completes and frame 2 is never requested.
- **Reset mid-frame**: assert `rst` during data bit 3.
  - `o_tx`=1 and `o_busy`=0 in the same cycle.
  - After release, the next byte is sent as a complete, correct frame.
